apb_master_req_if: RTL



---
 rtl/apb_master_req_if.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/apb_master_req_if.sv
// apb_master_req_if
// Single-outstanding APB initiator: turns a valid/ready request into an APB
// SETUP/ACCESS transfer and returns read data / error status on a valid/ready
// response channel. A bounded PREADY timeout keeps a hung slave from stalling
// the requester.
module apb_master_req_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    // request channel
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    input  logic                      req_write,
    // response channel
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    // APB master port
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // Counter must hold 0..TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Word-align by masking rather than slicing so every request bit is consumed.
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK = ~APB_ADDR_WIDTH'(3);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             done_ok;
    logic             done_tout;

    assign accept    = (state == IDLE) && req_valid;
    assign done_ok   = (state == ACCESS) && PREADY;
    // Completion in the would-timeout cycle takes priority: PREADY gates this.
    assign done_tout = TO_EN && (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

    // Status outputs decode straight from the state flops.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done_ok || done_tout) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // ACCESS wait counter: cleared in SETUP, counts PREADY-low cycles, saturates.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Address/data/direction latch only on request acceptance and hold afterwards.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
        end else if (accept) begin
            PADDR  <= req_addr & ADDR_MASK;
            PWDATA <= req_wdata;
            PWRITE <= req_write;
        end
    end

    // PSEL rises into SETUP, PENABLE into ACCESS; both drop when ACCESS ends.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else if (accept) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
        end else if (done_ok || done_tout) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else if (state == SETUP) begin
            PENABLE <= 1'b1;
        end
    end

    // Response capture at the end of ACCESS; fields stay stable through RESP.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done_ok) begin
            rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (done_tout) begin
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

endmodule
